// File: rtl/pulse_hold_gen_if.sv
// Command/status bundle for pulse_hold_gen.
// PULSE_HOLD_GEN_ABORT_EN adds the abort request line.
interface pulse_hold_gen_if #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned BURST_W = 3
);
    logic               start;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   gap;
    logic [BURST_W-1:0] count;
    logic               ready;
    logic               busy;
    logic               out;
    logic               done;
`ifdef PULSE_HOLD_GEN_ABORT_EN
    logic               abort;

    modport master (output start, len, gap, count, abort,
                    input  ready, busy, out, done);
    modport slave  (input  start, len, gap, count, abort,
                    output ready, busy, out, done);
`else
    modport master (output start, len, gap, count,
                    input  ready, busy, out, done);
    modport slave  (input  start, len, gap, count,
                    output ready, busy, out, done);
`endif
endinterface

// File: rtl/pulse_hold_gen.sv
// Drives a line high for a programmed number of cycles, optionally as a burst
// separated by low gaps. PULSE_HOLD_GEN_ABORT_EN enables early abort.
module pulse_hold_gen #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned BURST_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    pulse_hold_gen_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_cap_q, len_cap_d;
    logic [CNT_W-1:0]   gap_cap_q, gap_cap_d;
    logic [CNT_W-1:0]   len_cnt_q, len_cnt_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BURST_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               abort_req;

`ifdef PULSE_HOLD_GEN_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_cap_q   <= '0;
            gap_cap_q   <= '0;
            len_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_cap_q   <= len_cap_d;
            gap_cap_q   <= gap_cap_d;
            len_cnt_q   <= len_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_cap_d   = len_cap_q;
        gap_cap_d   = gap_cap_q;
        len_cnt_d   = len_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_cap_d = bus.len;
                    gap_cap_d = bus.gap;
                    if (bus.len == '0 || bus.count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_HIGH;
                        len_cnt_d   = bus.len - CNT_W'(1);
                        pulse_cnt_d = bus.count - BURST_W'(1);
                    end
                end
            end
            S_HIGH: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (len_cnt_q != '0) begin
                    len_cnt_d = len_cnt_q - CNT_W'(1);
                end else if (pulse_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    // gap of 0 is stretched to 1 so consecutive pulses stay separate
                    state_d   = S_GAP;
                    gap_cnt_d = (gap_cap_q == '0) ? '0 : gap_cap_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end else begin
                    state_d     = S_HIGH;
                    len_cnt_d   = len_cap_q - CNT_W'(1);
                    pulse_cnt_d = pulse_cnt_q - BURST_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        out_d   = (state_d == S_HIGH);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign bus.out   = out_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_hold_gen.sv
// Scoreboard bench for pulse_hold_gen: per-cycle {ready,busy,out,done}
// expectations are queued at command accept and popped on each falling edge.
module tb_pulse_hold_gen;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BURST_W = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pulse_hold_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    pulse_hold_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("ready", 8'(bus.ready), 8'(e[3]));
            check_val("busy",  8'(bus.busy),  8'(e[2]));
            check_val("out",   8'(bus.out),   8'(e[1]));
            check_val("done",  8'(bus.done),  8'(e[0]));
        end
    end

    task automatic push_v(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    // Expected activity for one accepted command, accept edge excluded.
    task automatic push_cmd(input int l, input int g, input int c);
        if (l != 0 && c != 0) begin
            for (int p = 0; p < c; p++) begin
                for (int i = 0; i < l; i++) push_v(4'b0110);
                if (p < c - 1)
                    for (int i = 0; i < ((g == 0) ? 1 : g); i++) push_v(4'b0100);
            end
        end
        push_v(4'b0101);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", 8'(exp_q.size()), 8'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_cmd(input int l, input int g, input int c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = CNT_W'(l);
        bus.gap   = CNT_W'(g);
        bus.count = BURST_W'(c);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_cmd(l, g, c);
        push_v(4'b1000);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.len   = '0;
        bus.gap   = '0;
        bus.count = '0;
`ifdef PULSE_HOLD_GEN_ABORT_EN
        bus.abort = 1'b0;
`endif
        // Reset state
        @(posedge clk);
        #1;
        repeat (3) push_v(4'b1000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drain();

        run_cmd(10, 3, 1);
        run_cmd(4, 2, 3);
        run_cmd(0, 4, 5);
        run_cmd(6, 2, 0);
        run_cmd(3, 0, 2);
        run_cmd(1, 0, 7);
        run_cmd(15, 15, 7);

        // start during a pulse is ignored and the captured fields stay put
        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd8; bus.gap = 4'd0; bus.count = 3'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_cmd(8, 0, 1);
        push_v(4'b1000);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd2; bus.gap = 4'd5; bus.count = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // start held through DONE is only taken once ready is back
        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd1; bus.gap = 4'd0; bus.count = 3'd1;
        @(posedge clk);
        #1;
        bus.len = 4'd2;
        push_cmd(1, 0, 1);
        push_v(4'b1000);
        push_cmd(2, 0, 1);
        push_v(4'b1000);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        // Reset during high-cycle 5 aborts silently
        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd8; bus.gap = 4'd1; bus.count = 3'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) push_v(4'b0110);
        repeat (4) push_v(4'b1000);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drain();

        run_cmd(2, 1, 2);

`ifdef PULSE_HOLD_GEN_ABORT_EN
        @(negedge clk);
        bus.start = 1'b1; bus.len = 4'd9; bus.gap = 4'd2; bus.count = 3'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) push_v(4'b0110);
        push_v(4'b0101);
        repeat (3) push_v(4'b1000);
        repeat (3) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
